// File: rtl/ram_stream_loader_pkg.sv
// Shared state encoding and small helpers for the RAM stream loader.
// Imported by the loader top and its byte-to-word packer.
package ram_stream_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_VERIFY  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [1:0] LAST_LANE      = 2'd3;

    // Additive checksum step; wraps modulo 2^32 by construction.
    function automatic logic [31:0] csum_add(input logic [31:0] acc, input logic [31:0] val);
        return acc + val;
    endfunction

endpackage

// File: rtl/ram_stream_loader_packer.sv
// Packs accepted bytes little-endian into a 32-bit word and pulses word_valid
// in the cycle after the fourth byte lands.
module ram_stream_loader_packer
    import ram_stream_loader_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        in_valid,
    input  logic        in_ready,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic        word_last,
    output logic        word_valid
);

    logic [1:0]                byte_cnt_reg;
    logic [31:0]               word_reg;
    logic                      word_valid_reg;
    logic                      accept;
    logic [BYTES_PER_WORD-1:0] lane_en;

    assign accept = in_valid & in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            assign lane_en[gi] = accept && (byte_cnt_reg == 2'(gi));
        end
    endgenerate

    // Combinational so the FSM can leave COLLECT on the edge that stores the top byte.
    assign word_last = lane_en[LAST_LANE];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            byte_cnt_reg   <= 2'd0;
            word_reg       <= 32'd0;
            word_valid_reg <= 1'b0;
        end else begin
            word_valid_reg <= word_last;
            if (clear)
                byte_cnt_reg <= 2'd0;
            else if (accept)
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (lane_en[i])
                    word_reg[8*i +: 8] <= in_data;
            end
        end
    end

    assign word       = word_reg;
    assign word_valid = word_valid_reg;

endmodule

// File: rtl/ram_stream_loader.sv
// Loads the word RAM from a byte stream, reads it back to verify a 32-bit
// additive checksum, and releases the CPU reset only after a clean verify.
module ram_stream_loader
    import ram_stream_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LOAD_WORDS = 512
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           checksum,
    output logic                  cpu_resetn
);

    localparam int               IDX_W    = $clog2(LOAD_WORDS) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LOAD_WORDS - 1);

    state_t                  state_reg, state_next;
    logic [IDX_W-1:0]        word_idx_reg, rd_idx_reg;
    logic [31:0]             wsum_reg, rsum_reg, checksum_reg;
    logic                    busy_reg, done_reg, error_reg, cpu_resetn_reg;
    logic [ADDR_WIDTH-3:0]   addr_word;
    logic [31:0]             word;
    logic                    word_last, word_valid, start_load;

    // start is only honoured when no load is in flight.
    assign start_load = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
    assign in_ready   = (state_reg == ST_COLLECT);

    ram_stream_loader_packer u_packer (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (start_load),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .word       (word),
        .word_last  (word_last),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        mem_wen    = 1'b0;
        mem_wdata  = 32'd0;
        addr_word  = '0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start)
                    state_next = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (word_last)
                    state_next = ST_WRITE;
            end
            ST_WRITE: begin
                mem_wen    = 1'b1;
                mem_wdata  = word;
                addr_word  = (ADDR_WIDTH-2)'(word_idx_reg);
                state_next = (word_idx_reg == LAST_IDX) ? ST_VERIFY : ST_COLLECT;
            end
            ST_VERIFY: begin
                addr_word = (ADDR_WIDTH-2)'(rd_idx_reg);
                if (rd_idx_reg == LAST_IDX)
                    state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign mem_address = {addr_word, 2'b00};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word_idx_reg   <= '0;
            rd_idx_reg     <= '0;
            wsum_reg       <= 32'd0;
            rsum_reg       <= 32'd0;
            checksum_reg   <= 32'd0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            cpu_resetn_reg <= 1'b0;
        end else begin
            // word_valid is high exactly in the WRITE cycle of each word.
            if (word_valid)
                wsum_reg <= csum_add(wsum_reg, word);
            case (state_reg)
                ST_WRITE: begin
                    if (word_idx_reg == LAST_IDX)
                        rd_idx_reg <= '0;
                    else
                        word_idx_reg <= word_idx_reg + IDX_W'(1);
                end
                ST_VERIFY: begin
                    rsum_reg   <= csum_add(rsum_reg, mem_rdata);
                    rd_idx_reg <= rd_idx_reg + IDX_W'(1);
                end
                ST_DONE: begin
                    busy_reg       <= 1'b0;
                    done_reg       <= 1'b1;
                    checksum_reg   <= wsum_reg;
                    error_reg      <= (rsum_reg != wsum_reg);
                    cpu_resetn_reg <= (rsum_reg == wsum_reg);
                end
                default: ;
            endcase
            // A new load overrides the DONE result update in the same cycle.
            if (start_load) begin
                word_idx_reg   <= '0;
                rd_idx_reg     <= '0;
                wsum_reg       <= 32'd0;
                rsum_reg       <= 32'd0;
                busy_reg       <= 1'b1;
                done_reg       <= 1'b0;
                error_reg      <= 1'b0;
                cpu_resetn_reg <= 1'b0;
            end
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign error      = error_reg;
    assign checksum   = checksum_reg;
    assign cpu_resetn = cpu_resetn_reg;

endmodule

// File: doc/ram_stream_loader.md
Name: ram_stream_loader

Overview:
- Bus initiator that fills the on-chip word RAM from an 8-bit byte stream, such as the UART receive path, before the CPU runs.
- Packs bytes little-endian into 32-bit words and writes them sequentially from byte address 0.
- After loading, reads every loaded word back and compares a 32-bit additive checksum.
- Holds the CPU in reset until a load verifies cleanly.

Parameters:
- ADDR_WIDTH, 12: byte-address width of the RAM port; word index is address[ADDR_WIDTH-1:2].
- LOAD_WORDS, 512: number of 32-bit words per load, 1..2^(ADDR_WIDTH-2).
- IDX_W, $clog2(LOAD_WORDS)+1: internal word-counter width (local).

Ports:
- clk  in  1  system clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a load.
- in_valid  in  1  byte available.
- in_data  in  8  byte value.
- in_ready  out  1  loader accepts byte this cycle.
- mem_wen  out  1  RAM write enable.
- mem_address  out  ADDR_WIDTH  RAM byte address, always word-aligned (bits [1:0]=0).
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, combinational from mem_address (same-cycle).
- busy  out  1  load or verify in progress.
- done  out  1  last load finished (pass or fail).
- error  out  1  last load's verify checksum mismatched.
- checksum  out  32  sum of written words, modulo 2^32.
- cpu_resetn  out  1  CPU reset, active-low.

Behaviour:
- Reset values (asynchronous on resetn low): state=IDLE, all counters, word buffer and sums =0, in_ready=0, mem_wen=0, mem_address=0, mem_wdata=0, busy=0, done=0, error=0, checksum=0, cpu_resetn=0.
- IDLE: in_ready=0, mem_wen=0.
  - start=1 -> COLLECT.
  - Clears word_idx, byte_cnt, wsum, rsum, done, error; sets busy=1; drives cpu_resetn=0.
- COLLECT: in_ready=1.
  - On in_valid&in_ready, in_data is stored into word bits [8*byte_cnt+7 : 8*byte_cnt] and byte_cnt increments mod 4.
  - When byte_cnt==3 and a byte is accepted -> WRITE. This is the next cycle, with the full word registered.
  - in_valid without an accept does nothing; no bytes are dropped.
- WRITE: exactly one cycle.
  - Drives mem_wen=1, mem_address=word_idx<<2, mem_wdata=word; in_ready=0.
  - wsum += word (wrapping).
  - If word_idx==LOAD_WORDS-1 -> VERIFY with rd_idx=0; else word_idx++ -> COLLECT.
- VERIFY: one word per cycle.
  - Drives mem_wen=0, mem_address=rd_idx<<2; in_ready=0.
  - rsum += mem_rdata; rd_idx++.
  - After the cycle with rd_idx==LOAD_WORDS-1 -> DONE.
- DONE:
  - Sets busy=0, done=1, checksum=wsum.
  - error=1 if the final rsum != wsum.
  - cpu_resetn=1 only if error=0, otherwise it stays 0.
  - Outputs hold until the next start. start in DONE behaves as in IDLE and re-asserts cpu_resetn=0.
- start while busy is ignored.
- Minimum load latency: 5*LOAD_WORDS cycles after start with in_valid held high (4 collect + 1 write per word), then LOAD_WORDS verify cycles. done asserts on cycle 6*LOAD_WORDS+1 after start.
- mem_wen is never asserted outside WRITE.
- Address wrap is impossible by the LOAD_WORDS bound.
- resetn low mid-operation aborts immediately to reset values. Partially written RAM content is not cleared.

Decomposition:
- Shared package/include holds the state encoding constants: IDLE=0, COLLECT=1, WRITE=2, VERIFY=3, DONE=4 (3-bit).
- Natural sub-module: byte_word_packer. Contains the byte counter, little-endian shift-in and word_valid pulse.
- The FSM, sums and address generation remain in ram_stream_loader.

Test Plan:
- LOAD_WORDS=4, in_valid held high, bytes 0x00..0x0F -> writes 0x03020100@0x000, 0x07060504@0x004, 0x0B0A0908@0x008, 0x0F0E0D0C@0x00C. Then checksum=0x24201C18, done=1, error=0, cpu_resetn=1 at cycle 25.
- Same load with random in_valid gaps -> identical writes and checksum, and no byte lost or duplicated.
- Bench RAM model corrupts word 2 (XOR 0x1) between write and verify -> error=1, done=1, cpu_resetn stays 0.
- start pulsed during COLLECT and during VERIFY -> ignored, sequence completes unchanged.
- resetn dropped after 6 bytes -> all outputs return to reset values. A new start then writes from address 0 with byte_cnt=0.
- Words of 0xFFFFFFFF ×4 -> checksum=0xFFFFFFFC (wrap), error=0.
